// File: rtl/channel_row_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// channel_row_scheduler_pkg : shared types for the channel row scheduler
// Revision: 1.0
// ============================================================================
package channel_row_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_DIVIDE = 2'd2,
    ST_READY  = 2'd3
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/next_enabled_channel.sv
`default_nettype none
// ============================================================================
// next_enabled_channel : lowest set bit of a mask strictly above an index
// Revision: 1.0
// ============================================================================
module next_enabled_channel #(
  parameter int N  = 10,
  parameter int NW = $clog2(N)
) (
  input  logic [N-1:0]     mask,
  input  logic signed [NW:0] after,
  output logic             found,
  output logic [NW-1:0]    idx
);

  // Descending scan so the last hit is the lowest qualifying bit.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(after))) begin
        found = 1'b1;
        idx   = NW'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/channel_row_scheduler.sv
`default_nettype none
// ============================================================================
// channel_row_scheduler : per-frame channel layout and per-row channel lookup
// Revision: 1.0
// ============================================================================
module channel_row_scheduler
  import channel_row_scheduler_pkg::*;
#(
  parameter int MAX_CHAN_COUNT = 10,
  parameter int OFFSET         = 0,
  parameter int VGA_VER_RES    = 480
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [MAX_CHAN_COUNT-1:0]            channel_enable,
  input  logic                                 frame_start,
  input  logic                                 row_strobe,
  input  logic [$clog2(VGA_VER_RES)-1:0]       pixel_row,
  output logic                                 layout_valid,
  output logic [$clog2(MAX_CHAN_COUNT+1)-1:0]  channel_count,
  output logic [$clog2(VGA_VER_RES)-1:0]       channel_height,
  output logic                                 is_channel,
  output logic [$clog2(MAX_CHAN_COUNT)-1:0]    channel_number,
  output logic [$clog2(VGA_VER_RES)-1:0]       row_in_channel
);

  localparam int RW = $clog2(VGA_VER_RES);
  localparam int CW = $clog2(MAX_CHAN_COUNT + 1);
  localparam int NW = $clog2(MAX_CHAN_COUNT);
  localparam int IW = $clog2(max_int(MAX_CHAN_COUNT, RW));
  localparam logic [RW-1:0] DIVIDEND   = RW'(VGA_VER_RES - OFFSET);
  localparam logic [RW:0]   ROW_OFFSET = (RW+1)'(OFFSET);

  state_e                    state_q, state_d;
  logic [MAX_CHAN_COUNT-1:0] en_q, en_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [CW-1:0]             count_q, count_d;
  logic [CW-1:0]             vis_q, vis_d;
  logic [RW-1:0]             rem_q, rem_d;
  logic [RW-1:0]             quo_q, quo_d;
  logic [RW-1:0]             height_q, height_d;
  logic                      valid_q, valid_d;
  logic                      is_ch_q, is_ch_d;
  logic [NW-1:0]             ch_q, ch_d;
  logic [RW-1:0]             ric_q, ric_d;

  logic [RW:0]               div_shift, div_diff, row_rel;
  logic                      div_ge, row_below, row_at;
  logic                      first_found, next_found;
  logic [NW-1:0]             first_idx, next_idx;
  logic signed [NW:0]        after_none, after_cur;

  assign after_none = '1;
  assign after_cur  = $signed({1'b0, ch_q});

  next_enabled_channel #(.N(MAX_CHAN_COUNT), .NW(NW)) u_first (
    .mask(en_q), .after(after_none), .found(first_found), .idx(first_idx)
  );

  next_enabled_channel #(.N(MAX_CHAN_COUNT), .NW(NW)) u_next (
    .mask(en_q), .after(after_cur), .found(next_found), .idx(next_idx)
  );

  // Restoring divide: dividend bits shift out of quo_q as quotient bits shift in.
  assign div_shift = {rem_q, quo_q[RW-1]};
  assign div_diff  = div_shift - (RW+1)'(count_q);
  assign div_ge    = (div_shift >= (RW+1)'(count_q));

  // Borrow of (pixel_row - OFFSET) flags rows above the channel area.
  assign row_rel   = {1'b0, pixel_row} - ROW_OFFSET;
  assign row_below = row_rel[RW];
  assign row_at    = (row_rel == '0);

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    idx_d    = idx_q;
    count_d  = count_q;
    vis_d    = vis_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    height_d = height_q;
    valid_d  = valid_q;
    is_ch_d  = is_ch_q;
    ch_d     = ch_q;
    ric_d    = ric_q;
    if (frame_start) begin
      en_d    = channel_enable;
      valid_d = 1'b0;
      idx_d   = '0;
      count_d = '0;
      state_d = ST_COUNT;
    end else begin
      case (state_q)
        ST_COUNT: begin
          count_d = count_q + CW'(en_q[idx_q]);
          idx_d   = idx_q + 1'b1;
          if (idx_q == IW'(MAX_CHAN_COUNT - 1)) begin
            idx_d   = '0;
            rem_d   = '0;
            quo_d   = DIVIDEND;
            state_d = ST_DIVIDE;
          end
        end
        ST_DIVIDE: begin
          rem_d = div_ge ? div_diff[RW-1:0] : div_shift[RW-1:0];
          quo_d = {quo_q[RW-2:0], div_ge};
          idx_d = idx_q + 1'b1;
          if (idx_q == IW'(RW - 1)) begin
            idx_d    = '0;
            height_d = (count_q == '0) ? '0 : quo_d;
            valid_d  = 1'b1;
            state_d  = ST_READY;
          end
        end
        ST_READY: begin
          if (row_strobe) begin
            if (row_below) begin
              is_ch_d = 1'b0;
            end else if (row_at) begin
              vis_d   = '0;
              ric_d   = '0;
              ch_d    = first_found ? first_idx : '0;
              is_ch_d = (count_q != '0);
            end else if (vis_q >= count_q) begin
              is_ch_d = 1'b0;
            end else if (ric_q == height_q - 1'b1) begin
              // Past the last channel the position freezes on its final row.
              vis_d   = vis_q + 1'b1;
              is_ch_d = ((vis_q + 1'b1) < count_q);
              if (next_found) begin
                ch_d  = next_idx;
                ric_d = '0;
              end
            end else begin
              ric_d   = ric_q + 1'b1;
              is_ch_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      en_q     <= '0;
      idx_q    <= '0;
      count_q  <= '0;
      vis_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      height_q <= '0;
      valid_q  <= 1'b0;
      is_ch_q  <= 1'b0;
      ch_q     <= '0;
      ric_q    <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      idx_q    <= idx_d;
      count_q  <= count_d;
      vis_q    <= vis_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      height_q <= height_d;
      valid_q  <= valid_d;
      is_ch_q  <= is_ch_d;
      ch_q     <= ch_d;
      ric_q    <= ric_d;
    end
  end

  assign layout_valid   = valid_q;
  assign channel_count  = count_q;
  assign channel_height = height_q;
  assign is_channel     = is_ch_q;
  assign channel_number = ch_q;
  assign row_in_channel = ric_q;

endmodule
`default_nettype wire

// File: tb/tb_channel_row_scheduler.sv
`default_nettype none
// ============================================================================
// tb_channel_row_scheduler : scoreboard bench for channel_row_scheduler
// Revision: 1.0
// ============================================================================
module tb_channel_row_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] channel_enable = '0;
  logic       frame_start = 1'b0;
  logic       row_strobe = 1'b0;
  logic [8:0] pixel_row = '0;

  logic       lv0, lv1, ic0, ic1;
  logic [3:0] cc0, cc1, cn0, cn1;
  logic [8:0] h0, h1, r0, r1;

  channel_row_scheduler #(.MAX_CHAN_COUNT(10), .OFFSET(0), .VGA_VER_RES(480)) dut (
    .clk(clk), .rst(rst), .channel_enable(channel_enable), .frame_start(frame_start),
    .row_strobe(row_strobe), .pixel_row(pixel_row), .layout_valid(lv0),
    .channel_count(cc0), .channel_height(h0), .is_channel(ic0),
    .channel_number(cn0), .row_in_channel(r0)
  );

  channel_row_scheduler #(.MAX_CHAN_COUNT(10), .OFFSET(32), .VGA_VER_RES(480)) dut_off (
    .clk(clk), .rst(rst), .channel_enable(channel_enable), .frame_start(frame_start),
    .row_strobe(row_strobe), .pixel_row(pixel_row), .layout_valid(lv1),
    .channel_count(cc1), .channel_height(h1), .is_channel(ic1),
    .channel_number(cn1), .row_in_channel(r1)
  );

  always #5 clk = ~clk;

  logic sel = 1'b0;
  logic       m_valid, m_is;
  logic [3:0] m_count, m_ch;
  logic [8:0] m_height, m_ric;
  assign m_valid  = sel ? lv1 : lv0;
  assign m_count  = sel ? cc1 : cc0;
  assign m_height = sel ? h1  : h0;
  assign m_is     = sel ? ic1 : ic0;
  assign m_ch     = sel ? cn1 : cn0;
  assign m_ric    = sel ? r1  : r0;

  typedef struct {int cnt; int h; int cyc;} lay_t;
  typedef struct {int mode; int ic; int ch; int ric;} row_t;
  lay_t lay_q[$];
  row_t row_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic strobe_seen = 1'b0;
  logic prev_valid = 1'b0;
  lay_t mon_l;
  row_t mon_r;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    strobe_seen <= row_strobe;
  end

  // Monitor: layout results on layout_valid rising, row results after each strobe.
  always @(negedge clk) begin
    if (m_valid && !prev_valid) begin
      if (lay_q.size() == 0) begin
        check("layout_unexpected", 1, 0);
      end else begin
        mon_l = lay_q.pop_front();
        check("channel_count", int'(m_count), mon_l.cnt);
        check("channel_height", int'(m_height), mon_l.h);
        check("layout_latency", cyc, mon_l.cyc);
      end
    end
    prev_valid = m_valid;
    if (strobe_seen) begin
      if (row_q.size() == 0) begin
        check("row_unexpected", 1, 0);
      end else begin
        mon_r = row_q.pop_front();
        if (mon_r.mode >= 1) check($sformatf("is_channel[%0d]", pixel_row), int'(m_is), mon_r.ic);
        if (mon_r.mode == 2) begin
          check($sformatf("channel_number[%0d]", pixel_row), int'(m_ch), mon_r.ch);
          check($sformatf("row_in_channel[%0d]", pixel_row), int'(m_ric), mon_r.ric);
        end
      end
    end
  end

  task automatic wait_layout();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_valid) return;
    end
    check("layout_timeout", 0, 1);
  endtask

  task automatic pulse_frame(input logic [9:0] mask);
    channel_enable = mask;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic start_frame(input logic [9:0] mask, input int cnt, input int h);
    lay_q.push_back('{cnt, h, cyc + 20});
    pulse_frame(mask);
    wait_layout();
  endtask

  // mode 0: not checked, 1: is_channel only, 2: all row outputs
  task automatic row(input int r, input int mode, input int ic, input int ch, input int ric);
    row_q.push_back('{mode, ic, ch, ric});
    pixel_row = 9'(r);
    row_strobe = 1'b1;
    @(negedge clk);
    row_strobe = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int r = lo; r <= hi; r++) row(r, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_layout_valid", int'(m_valid), 0);
    check("rst_count", int'(m_count), 0);
    check("rst_height", int'(m_height), 0);
    check("rst_is_channel", int'(m_is), 0);
    check("rst_channel_number", int'(m_ch), 0);
    check("rst_row_in_channel", int'(m_ric), 0);
    rst = 1'b0;
    @(negedge clk);

    // Three channels: 0, 2, 5
    start_frame(10'b100101, 3, 160);
    row(0, 2, 1, 0, 0);
    run_rows(1, 159);
    row(160, 2, 1, 2, 0);
    run_rows(161, 319);
    row(320, 2, 1, 5, 0);
    run_rows(321, 478);
    row(479, 2, 1, 5, 159);

    // Seven channels with a four-row remainder
    start_frame(10'b1111111, 7, 68);
    row(0, 2, 1, 0, 0);
    run_rows(1, 474);
    row(475, 2, 1, 6, 67);
    for (int r = 476; r <= 479; r++) row(r, 2, 0, 6, 67);

    // Empty mask
    start_frame(10'b0, 0, 0);
    row(0, 1, 0, 0, 0);
    run_rows(1, 239);
    row(240, 1, 0, 0, 0);
    run_rows(241, 478);
    row(479, 1, 0, 0, 0);

    // Mask change mid-frame is deferred to the next frame
    start_frame(10'b1, 1, 480);
    row(0, 2, 1, 0, 0);
    run_rows(1, 99);
    channel_enable = 10'b11;
    row(100, 2, 1, 0, 100);
    run_rows(101, 478);
    row(479, 2, 1, 0, 479);
    check("height_held", int'(m_height), 480);
    start_frame(10'b11, 2, 240);
    row(0, 2, 1, 0, 0);
    run_rows(1, 239);
    row(240, 2, 1, 1, 0);

    // Restart during DIVIDE
    pulse_frame(10'b100101);
    repeat (14) @(negedge clk);
    check("valid_during_divide", int'(m_valid), 0);
    start_frame(10'b11, 2, 240);

    // Reset during DIVIDE
    pulse_frame(10'h3FF);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_layout_valid", int'(m_valid), 0);
    check("midrst_count", int'(m_count), 0);
    check("midrst_height", int'(m_height), 0);
    check("midrst_is_channel", int'(m_is), 0);
    check("midrst_row_in_channel", int'(m_ric), 0);
    repeat (30) @(negedge clk);
    check("midrst_stays_idle", int'(m_valid), 0);

    // OFFSET=32 instance
    sel = 1'b1;
    @(negedge clk);
    start_frame(10'b11, 2, 224);
    run_rows(0, 30);
    row(31, 1, 0, 0, 0);
    row(32, 2, 1, 0, 0);
    run_rows(33, 255);
    row(256, 2, 1, 1, 0);

    repeat (3) @(negedge clk);
    check("layout_queue_empty", lay_q.size(), 0);
    check("row_queue_empty", row_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/channel_row_scheduler.md
# channel_row_scheduler

Sequential replacement for the per-pixel divide in the multi-channel VGA display path. Once per frame, during vertical blank, it latches the channel enable mask, counts the enabled channels and computes the channel height with an iterative divider. During active video it tracks, row by row, which enabled channel owns the current pixel row and the row offset inside that channel. It sits between the VGA timing generator and the waveform renderers.

## Interface
- MAX_CHAN_COUNT, 10, number of channel enable bits
- OFFSET, 0, first pixel row usable by channels; rows above it belong to no channel
- VGA_VER_RES, from vga.h (480), visible row count
- clk  in  1  pixel clock
- rst  in  1  reset: synchronous, active-high
- channel_enable  in  MAX_CHAN_COUNT  requested channel mask; sampled only on frame_start
- frame_start  in  1  one-cycle pulse at the start of vertical blank
- row_strobe  in  1  one-cycle pulse when pixel_row takes a new active-row value
- pixel_row  in  $clog2(VGA_VER_RES)  current active row; valid with row_strobe
- layout_valid  out  1  count and height are computed for this frame
- channel_count  out  $clog2(MAX_CHAN_COUNT+1)  number of enabled channels in the latched mask
- channel_height  out  $clog2(VGA_VER_RES)  floor((VGA_VER_RES-OFFSET)/channel_count); 0 when the count is 0
- is_channel  out  1  current row belongs to a channel
- channel_number  out  $clog2(MAX_CHAN_COUNT)  physical channel index of the current row
- row_in_channel  out  $clog2(VGA_VER_RES)  row offset inside the current channel

## Operation
- FSM states: IDLE, COUNT, DIVIDE, READY. On reset, all outputs are 0 and the state is IDLE.
- **frame_start (any state):**
  - Latch channel_enable into en_q.
  - Clear layout_valid.
  - Enter COUNT.
  - frame_start while in COUNT or DIVIDE restarts the sequence.
- **COUNT:** scan one bit of en_q per cycle for MAX_CHAN_COUNT cycles, accumulating channel_count. Then enter DIVIDE.
- **DIVIDE:**
  - Restoring division of (VGA_VER_RES-OFFSET) by channel_count.
  - One quotient bit per cycle, $clog2(VGA_VER_RES) cycles.
  - A count of 0 still runs the full divide; the result is forced to 0.
  - Then enter READY and set layout_valid.
- **Row tracking on row_strobe (READY only; ignored otherwise):**
  - pixel_row < OFFSET: is_channel=0.
  - pixel_row == OFFSET:
    - vis=0, row_in_channel=0.
    - channel_number = lowest set bit of en_q.
  - pixel_row > OFFSET and row_in_channel == channel_height-1:
    - row_in_channel=0, vis=vis+1.
    - channel_number = next set bit of en_q above the current channel_number.
  - pixel_row > OFFSET otherwise: row_in_channel increments.
  - is_channel = (pixel_row >= OFFSET) && channel_count != 0 && vis < channel_count.
  - Leftover rows after the last channel (the division remainder) have is_channel=0; channel_number and row_in_channel hold their last values.
- **Next set bit lookup:** when no higher bit is set, channel_number holds its value. vis then equals channel_count, so is_channel is 0.
- **channel_enable changes** outside frame_start have no effect until the next frame.

## Timing
- frame_start at cycle T: layout_valid=1 from cycle T+1+MAX_CHAN_COUNT+$clog2(VGA_VER_RES), which is T+20 with the defaults. This must complete within vertical blank.
- Row outputs are registered: valid one cycle after row_strobe and held until the next row_strobe.
- rst mid-operation: cleared next cycle. FSM returns to IDLE; no outputs resume until a frame_start.
- row_strobe and frame_start in the same cycle: frame_start wins and the row is ignored.

## Structure
- VGA_VER_RES and the other resolution constants come from the shared vga.h header. No new shared constants.
- One sub-module, next_enabled_channel: combinational priority finder returning the lowest set bit of a mask strictly above a given index, plus a found flag. The same finder with index -1 gives the first enabled channel.
- Divider and counter stay inline in the FSM.

## Test plan
Defaults used throughout: MAX=10, OFFSET=0, VER=480.
- **Mask 'b100101:**
  - count=3, height=160, layout_valid at T+20.
  - Row 0 → ch0, row 160 → ch2, row 320 → ch5.
  - Row 479 → ch5 with row_in_channel=159.
- **Mask 'b1111111 (7 channels):**
  - height=68.
  - Row 475 → ch6, row_in_channel=67.
  - Rows 476–479 → is_channel=0.
- **Mask 0:** count=0, height=0, layout_valid set; is_channel=0 on every row.
- **Mask change mid-frame:** change the mask 'b1 → 'b11 at row 100. Outputs stay ch0 with height 480 until the next frame_start; the next frame gives height 240.
- **Restart:** frame_start during DIVIDE restarts the sequence; layout_valid arrives 20 cycles after the second pulse. A rst pulse mid-DIVIDE zeros all outputs.
- **OFFSET=32, mask 'b11:**
  - height=224.
  - Row 31 → is_channel=0, row 32 → ch0 with row_in_channel=0, row 256 → ch1.
